// File: rtl/counter_b32_ctrl_pkg.sv
// Shared definitions for the counter_b32 command sequencer: counter mode
// encodings and FSM state encodings (also used by the bench monitor).
package counter_b32_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_DN3 = 2'b10,
    MODE_LD  = 2'b11
  } cnt_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4
  } ctrl_state_t;

  // States in which the counter is enabled and rco pulses are counted.
  function automatic logic drives_counter(input ctrl_state_t st);
    return (st == ST_LOAD) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/ctrl_run_timer.sv
// Loadable down-counter that times the RUN phase; zero marks the final cycle.
module ctrl_run_timer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LEN_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/counter_b32_ctrl.sv
// Command sequencer in front of counter_b32: runs one load/count command at a
// time and returns the final count plus a saturating rco tally.
module counter_b32_ctrl
  import counter_b32_ctrl_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int RCO_W = 8
) (
  input  logic             ctrl_clk,
  input  logic             ctrl_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [31:0]      cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic             cnt_enable,
  output logic [1:0]       cnt_mode,
  output logic [31:0]      cnt_D,
  input  logic [31:0]      cnt_Q,
  input  logic             cnt_rco,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_value,
  output logic [RCO_W-1:0] rsp_rco_cnt,
  output logic             rsp_aborted,
  output logic             busy
);

  ctrl_state_t      state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [31:0]      data_reg, data_next;
  logic [RCO_W-1:0] rco_cnt_reg, rco_cnt_next;
  logic             aborted_reg, aborted_next;

  logic             cmd_ready_reg, cmd_ready_next;
  logic             busy_reg, busy_next;
  logic             cnt_enable_reg, cnt_enable_next;
  logic [1:0]       cnt_mode_reg, cnt_mode_next;
  logic [31:0]      cnt_d_reg, cnt_d_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [31:0]      rsp_value_reg, rsp_value_next;
  logic [RCO_W-1:0] rsp_rco_cnt_reg, rsp_rco_cnt_next;
  logic             rsp_aborted_reg, rsp_aborted_next;

  logic             timer_load;
  logic [LEN_W-1:0] timer_load_val;
  logic             timer_dec;
  logic             timer_zero;
  logic             accept;

  ctrl_run_timer #(
    .LEN_W (LEN_W)
  ) u_run_timer (
    .clk      (ctrl_clk),
    .rst      (ctrl_reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign accept = (state_reg == ST_IDLE) && cmd_valid && cmd_ready_reg;

  always_comb begin
    state_next       = state_reg;
    mode_next        = mode_reg;
    data_next        = data_reg;
    rco_cnt_next     = rco_cnt_reg;
    aborted_next     = aborted_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_value_next   = rsp_value_reg;
    rsp_rco_cnt_next = rsp_rco_cnt_reg;
    rsp_aborted_next = rsp_aborted_reg;
    timer_load       = 1'b0;
    // Preload len-1 so the zero flag marks the last enabled cycle.
    timer_load_val   = cmd_len - 1'b1;
    timer_dec        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          mode_next    = cmd_mode;
          data_next    = cmd_data;
          rco_cnt_next = '0;
          aborted_next = 1'b0;
          if (cmd_mode == MODE_LD) begin
            state_next = ST_LOAD;
          end else if (cmd_len != '0) begin
            state_next = ST_RUN;
            timer_load = 1'b1;
          end else begin
            state_next = ST_SETTLE;
          end
        end
      end
      ST_LOAD: begin
        state_next = ST_SETTLE;
      end
      ST_RUN: begin
        if (cmd_abort) begin
          aborted_next = 1'b1;
          state_next   = ST_SETTLE;
        end else if (timer_zero) begin
          state_next = ST_SETTLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        state_next       = ST_RESP;
        rsp_valid_next   = 1'b1;
        rsp_value_next   = cnt_Q;
        rsp_rco_cnt_next = rco_cnt_reg;
        rsp_aborted_next = aborted_reg;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (drives_counter(state_reg) && cnt_rco && (rco_cnt_reg != '1)) begin
      rco_cnt_next = rco_cnt_reg + 1'b1;
    end
  end

  // Counter-facing and handshake outputs are decoded from the next state so
  // they change on the same edge as the state register.
  always_comb begin
    cmd_ready_next  = (state_next == ST_IDLE);
    busy_next       = (state_next != ST_IDLE);
    cnt_enable_next = drives_counter(state_next);
    cnt_mode_next   = cnt_mode_reg;
    cnt_d_next      = '0;
    if (state_next == ST_LOAD) begin
      cnt_mode_next = MODE_LD;
      cnt_d_next    = data_next;
    end else if (state_next == ST_RUN) begin
      cnt_mode_next = mode_next;
    end
  end

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= '0;
      data_reg        <= '0;
      rco_cnt_reg     <= '0;
      aborted_reg     <= 1'b0;
      cmd_ready_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      cnt_enable_reg  <= 1'b0;
      cnt_mode_reg    <= '0;
      cnt_d_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_value_reg   <= '0;
      rsp_rco_cnt_reg <= '0;
      rsp_aborted_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mode_reg        <= mode_next;
      data_reg        <= data_next;
      rco_cnt_reg     <= rco_cnt_next;
      aborted_reg     <= aborted_next;
      cmd_ready_reg   <= cmd_ready_next;
      busy_reg        <= busy_next;
      cnt_enable_reg  <= cnt_enable_next;
      cnt_mode_reg    <= cnt_mode_next;
      cnt_d_reg       <= cnt_d_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_value_reg   <= rsp_value_next;
      rsp_rco_cnt_reg <= rsp_rco_cnt_next;
      rsp_aborted_reg <= rsp_aborted_next;
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign busy        = busy_reg;
  assign cnt_enable  = cnt_enable_reg;
  assign cnt_mode    = cnt_mode_reg;
  assign cnt_D       = cnt_d_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_value   = rsp_value_reg;
  assign rsp_rco_cnt = rsp_rco_cnt_reg;
  assign rsp_aborted = rsp_aborted_reg;

endmodule
